// File: rtl/pipe_pkg.sv
// Shared types for the decode-to-execute hand-off: ALU control codes,
// the buffered operation record and the buffer occupancy states.
package pipe_pkg;

  localparam int PIPE_DW = 32;
  localparam int PIPE_RW = 5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;

  typedef struct packed {
    logic [PIPE_RW-1:0] rs;
    logic [PIPE_RW-1:0] rt;
    logic [PIPE_DW-1:0] data1;
    logic [PIPE_DW-1:0] data2;
    logic [2:0]         alu_ctrl;
    logic [PIPE_RW-1:0] rd;
    logic               reg_write;
  } ex_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  typedef enum logic [1:0] {
    HEAD_HOLD = 2'd0,
    HEAD_IN   = 2'd1,
    HEAD_SKID = 2'd2
  } head_sel_t;

  function automatic logic alu_ctrl_illegal(input logic [2:0] ctrl);
    return ctrl > ALU_MUL;
  endfunction

endpackage

// File: rtl/ex_bypass_update.sv
// Refreshes an entry's operands from the write-back port so a waiting
// operation never holds a stale register value. Register 0 is never refreshed.
module ex_bypass_update
  import pipe_pkg::*;
(
  input  ex_entry_t          entry,
  input  logic               wb_en,
  input  logic [PIPE_RW-1:0] wb_rd,
  input  logic [PIPE_DW-1:0] wb_data,
  output ex_entry_t          entry_upd
);

  logic wb_live;

  assign wb_live = wb_en && (wb_rd != '0);

  always_comb begin
    entry_upd = entry;
    if (wb_live && (wb_rd == entry.rs)) entry_upd.data1 = wb_data;
    if (wb_live && (wb_rd == entry.rt)) entry_upd.data2 = wb_data;
  end

endmodule

// File: rtl/id_ex_buffer.sv
// Two-entry elastic buffer (head + skid) between decode and the execute ALU,
// with write-back operand refresh on every resident and incoming entry.
//
// state     | meaning
// ----------+------------------------------------------------
// OCC_EMPTY | no entry held, valid_o=0, ready_o=1
// OCC_ONE   | head valid, skid empty, ready_o=1
// OCC_FULL  | head and skid valid, ready_o=0
module id_ex_buffer
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int RW = PIPE_RW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic [2:0]    alu_ctrl_i,
  input  logic [RW-1:0] rd_i,
  input  logic          reg_write_i,
  input  logic          wb_en_i,
  input  logic [RW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data1_o,
  output logic [DW-1:0] data2_o,
  output logic [2:0]    alu_ctrl_o,
  output logic [RW-1:0] rd_o,
  output logic          reg_write_o,
  output logic          illegal_o,
  output logic [1:0]    count_o
);

  occ_state_t state_q, state_d;
  head_sel_t  head_sel;
  logic       skid_load;
  logic       accept, consume;
  ex_entry_t  head_q, skid_q;
  ex_entry_t  in_entry, in_upd, head_upd, skid_upd;

  always_comb begin
    in_entry           = '0;
    in_entry.rs        = rs_i;
    in_entry.rt        = rt_i;
    in_entry.data1     = data1_i;
    in_entry.data2     = data2_i;
    in_entry.alu_ctrl  = alu_ctrl_i;
    in_entry.rd        = rd_i;
    in_entry.reg_write = reg_write_i;
  end

  ex_bypass_update u_bypass_in (
    .entry     (in_entry),
    .wb_en     (wb_en_i),
    .wb_rd     (wb_rd_i),
    .wb_data   (wb_data_i),
    .entry_upd (in_upd)
  );

  ex_bypass_update u_bypass_head (
    .entry     (head_q),
    .wb_en     (wb_en_i),
    .wb_rd     (wb_rd_i),
    .wb_data   (wb_data_i),
    .entry_upd (head_upd)
  );

  ex_bypass_update u_bypass_skid (
    .entry     (skid_q),
    .wb_en     (wb_en_i),
    .wb_rd     (wb_rd_i),
    .wb_data   (wb_data_i),
    .entry_upd (skid_upd)
  );

  assign valid_o = (state_q != OCC_EMPTY);
  assign ready_o = (state_q != OCC_FULL);
  assign accept  = valid_i && ready_o;
  assign consume = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    head_sel  = HEAD_HOLD;
    skid_load = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          head_sel = HEAD_IN;
          state_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && consume) begin
          head_sel = HEAD_IN;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = OCC_FULL;
        end else if (consume) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (consume) begin
          head_sel = HEAD_SKID;
          state_d  = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // A redirect wins over any accept or consume in the same cycle.
    if (flush_i) begin
      state_d   = OCC_EMPTY;
      head_sel  = HEAD_HOLD;
      skid_load = 1'b0;
    end
  end

  // Payload keeps refreshing even while its slot is empty; that is harmless
  // because valid bits live in the occupancy state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      case (head_sel)
        HEAD_IN:   head_q <= in_upd;
        HEAD_SKID: head_q <= skid_upd;
        default:   head_q <= head_upd;
      endcase
      skid_q <= skid_load ? in_upd : skid_upd;
    end
  end

  assign data1_o     = head_q.data1;
  assign data2_o     = head_q.data2;
  assign alu_ctrl_o  = head_q.alu_ctrl;
  assign rd_o        = head_q.rd;
  assign reg_write_o = head_q.reg_write;
  assign illegal_o   = valid_o && alu_ctrl_illegal(head_q.alu_ctrl);
  assign count_o     = {state_q == OCC_FULL, state_q == OCC_ONE};

endmodule

// File: tb/tb_id_ex_buffer.sv
// Directed self-checking bench for id_ex_buffer: handshake, ordering,
// write-back refresh, flush, illegal decode and asynchronous reset.
module tb_id_ex_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [31:0] data1_i, data2_i;
  logic [2:0]  alu_ctrl_i;
  logic        reg_write_i;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data1_o, data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        illegal_o;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_buffer #(.DW(32), .RW(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .alu_ctrl_i  (alu_ctrl_i),
    .rd_i        (rd_i),
    .reg_write_i (reg_write_i),
    .wb_en_i     (wb_en_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .rd_o        (rd_o),
    .reg_write_o (reg_write_o),
    .illegal_o   (illegal_o),
    .count_o     (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_op(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [2:0] ctrl, input logic [4:0] rd);
    valid_i     = 1'b1;
    rs_i        = rs;
    rt_i        = rt;
    data1_i     = d1;
    data2_i     = d2;
    alu_ctrl_i  = ctrl;
    rd_i        = rd;
    reg_write_i = 1'b1;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_en_i   = en;
    wb_rd_i   = rd;
    wb_data_i = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    rs_i = '0; rt_i = '0; rd_i = '0; data1_i = '0; data2_i = '0;
    alu_ctrl_i = '0; reg_write_i = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);

    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_data1", data1_o, 0);
    chk("rst_rd", rd_o, 0);

    @(negedge clk_i);
    rst_i = 1'b1;

    // single add passes through with one cycle latency
    ready_i = 1'b1;
    drive_op(5'd1, 5'd2, 32'd5, 32'd7, 3'd0, 5'd3);
    step();
    valid_i = 1'b0;
    chk("t1_valid", valid_o, 1);
    chk("t1_data1", data1_o, 5);
    chk("t1_data2", data2_o, 7);
    chk("t1_rd", rd_o, 3);
    chk("t1_ctrl", alu_ctrl_o, 0);
    chk("t1_regw", reg_write_o, 1);
    chk("t1_count", count_o, 1);
    step();
    chk("t1_drain_valid", valid_o, 0);
    chk("t1_drain_count", count_o, 0);

    // backpressure, skid fill and in-order drain
    ready_i = 1'b0;
    drive_op(5'd9, 5'd10, 32'd10, 32'd11, 3'd1, 5'd1);
    step();
    chk("t2_count1", count_o, 1);
    chk("t2_ready1", ready_o, 1);
    drive_op(5'd9, 5'd10, 32'd20, 32'd21, 3'd4, 5'd2);
    step();
    chk("t2_count2", count_o, 2);
    chk("t2_ready_low", ready_o, 0);
    drive_op(5'd9, 5'd10, 32'd30, 32'd31, 3'd3, 5'd4);
    step();
    chk("t2_hold_count", count_o, 2);
    chk("t2_hold_head", data1_o, 10);
    ready_i = 1'b1;
    step();
    chk("t2_second_data", data1_o, 20);
    chk("t2_second_rd", rd_o, 2);
    chk("t2_mul_legal", illegal_o, 0);
    chk("t2_count_after", count_o, 1);
    chk("t2_ready_rise", ready_o, 1);
    step();
    valid_i = 1'b0;
    chk("t2_third_data", data1_o, 30);
    chk("t2_third_ctrl", alu_ctrl_o, 3);
    chk("t2_third_count", count_o, 1);
    step();
    chk("t2_empty", count_o, 0);

    // resident head refresh on rs and rt, r0 never refreshed
    ready_i = 1'b0;
    drive_op(5'd4, 5'd5, 32'd1, 32'd2, 3'd0, 5'd7);
    step();
    valid_i = 1'b0;
    chk("t3_pre_data1", data1_o, 1);
    drive_wb(1'b1, 5'd4, 32'd99);
    step();
    chk("t3_bp_data1", data1_o, 99);
    chk("t3_bp_data2_kept", data2_o, 2);
    drive_wb(1'b1, 5'd5, 32'h1234);
    step();
    chk("t3_bp_data2", data2_o, 32'h1234);
    chk("t3_bp_data1_kept", data1_o, 99);
    drive_wb(1'b0, 5'd0, 32'd0);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    drive_op(5'd0, 5'd0, 32'd11, 32'd22, 3'd0, 5'd1);
    drive_wb(1'b1, 5'd0, 32'd77);
    step();
    valid_i = 1'b0;
    step();
    drive_wb(1'b0, 5'd0, 32'd0);
    chk("t3_r0_data1", data1_o, 11);
    chk("t3_r0_data2", data2_o, 22);
    ready_i = 1'b1;
    step();
    chk("t3_empty", count_o, 0);

    // incoming refresh, skid resident refresh, refresh while moving to head
    ready_i = 1'b0;
    drive_op(5'd6, 5'd6, 32'd1, 32'd2, 3'd2, 5'd8);
    drive_wb(1'b1, 5'd6, 32'h55);
    step();
    drive_wb(1'b0, 5'd0, 32'd0);
    chk("t4_in_data1", data1_o, 32'h55);
    chk("t4_in_data2", data2_o, 32'h55);
    drive_op(5'd7, 5'd8, 32'd3, 32'd4, 3'd1, 5'd9);
    step();
    valid_i = 1'b0;
    drive_wb(1'b1, 5'd7, 32'hAA);
    step();
    chk("t4_full", count_o, 2);
    chk("t4_head_untouched", data1_o, 32'h55);
    ready_i = 1'b1;
    drive_wb(1'b1, 5'd8, 32'hBB);
    step();
    drive_wb(1'b0, 5'd0, 32'd0);
    chk("t4_skid_data1", data1_o, 32'hAA);
    chk("t4_move_data2", data2_o, 32'hBB);
    chk("t4_move_rd", rd_o, 9);
    step();
    chk("t4_empty", count_o, 0);

    // flush with a full buffer and a same-cycle input
    ready_i = 1'b0;
    drive_op(5'd1, 5'd1, 32'd1, 32'd1, 3'd0, 5'd1);
    step();
    drive_op(5'd2, 5'd2, 32'd2, 32'd2, 3'd0, 5'd2);
    step();
    chk("t5_full", count_o, 2);
    flush_i = 1'b1;
    drive_op(5'd3, 5'd3, 32'd3, 32'd3, 3'd0, 5'd3);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("t5_flush_valid", valid_o, 0);
    chk("t5_flush_count", count_o, 0);
    chk("t5_flush_ready", ready_o, 1);
    step();
    chk("t5_input_dropped", valid_o, 0);

    // illegal decode, then asynchronous reset mid-stream
    drive_op(5'd1, 5'd2, 32'd40, 32'd41, 3'd6, 5'd5);
    step();
    chk("t6_illegal", illegal_o, 1);
    chk("t6_ctrl", alu_ctrl_o, 6);
    drive_op(5'd1, 5'd2, 32'd50, 32'd51, 3'd5, 5'd6);
    step();
    valid_i = 1'b0;
    chk("t6_full", count_o, 2);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_arst_valid", valid_o, 0);
    chk("t6_arst_count", count_o, 0);
    chk("t6_arst_ready", ready_o, 1);
    chk("t6_arst_illegal", illegal_o, 0);
    chk("t6_arst_data1", data1_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    chk("t6_post_rst_valid", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_buffer.md
# id_ex_buffer

Two-entry elastic buffer between instruction decode and the execute-stage ALU. It holds decoded ALU operations (operands, 3-bit ALU control, destination register) under a valid/ready handshake. While an operation is waiting, the buffer refreshes its operands from the write-back bypass port so the ALU never consumes a stale register value. A flush input discards everything buffered on a branch redirect.

## Interface
Parameters:
- DW, 32, operand/result width
- RW, 5, register index width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low (0 = reset)
- flush_i  in  1  discard all buffered entries and any same-cycle input
- valid_i  in  1  upstream has an operation
- ready_o  out  1  buffer can accept
- rs_i, rt_i  in  RW  source register indices
- data1_i, data2_i  in  DW  operand values read from the register file
- alu_ctrl_i  in  3  0=add, 1=sub, 2=and, 3=or, 4=mul
- rd_i  in  RW  destination register
- reg_write_i  in  1  operation writes rd
- wb_en_i  in  1  write-back occurring this cycle
- wb_rd_i  in  RW  write-back register
- wb_data_i  in  DW  write-back value
- valid_o  out  1  head entry present
- ready_i  in  1  ALU stage consumes the head
- data1_o, data2_o  out  DW  head operands
- alu_ctrl_o  out  3  head ALU control
- rd_o  out  RW  head destination
- reg_write_o  out  1  head write enable
- illegal_o  out  1  head alu_ctrl is 5, 6 or 7
- count_o  out  2  occupancy: 0, 1 or 2

## Operation
- Storage is two entries, head and skid. Each entry holds rs, rt, data1, data2, alu_ctrl, rd, reg_write and a valid bit. The buffer is strict FIFO.
- Accept when valid_i && ready_o. Consume when valid_o && ready_i.
- `ready_o = !skid.valid`, so the buffer accepts whenever the skid entry is empty.
- Edge cases, all with flush_i=0:
  - Empty and accept: head <= input.
  - Head only, consume and accept: head <= input.
  - Head only, accept, no consume: skid <= input.
  - Head only, consume, no accept: head empties.
  - Full and consume: head <= skid, skid empties. No accept is possible that cycle.
- Bypass rule, applied on every edge to each resident entry and to the incoming payload before it is stored:
  - If wb_en_i && wb_rd_i != 0 && wb_rd_i == rs, replace data1 with wb_data_i.
  - If wb_en_i && wb_rd_i != 0 && wb_rd_i == rt, replace data2 with wb_data_i.
  - rs == rt == wb_rd_i updates both operands.
  - The bypass also applies to an entry that is moving from skid to head on the same edge.
- Register 0 is never bypassed.
- flush_i has priority over everything. On the next edge both valid bits clear, and any accept or consume that cycle has no effect on state.
- illegal_o is decoded combinationally from the head's alu_ctrl. It is 0 when valid_o=0. The buffer still passes illegal entries through; the ALU stage treats them as no-ops.
- All payload outputs come straight from the head registers. No arithmetic is done in this block.

## Timing
- Reset state (rst_i=0, asynchronous):
  - All valid bits clear, all payload registers 0.
  - Outputs: valid_o=0, ready_o=1, count_o=0, illegal_o=0, and all payload outputs 0.
- Inputs are ignored while rst_i=0. Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an operation accepted at edge N appears on valid_o after edge N, provided the head was empty or consumed at edge N.
- Throughput: one operation per cycle while ready_i=1.
- ready_o falls the cycle after a second entry is captured. It rises the cycle after the head is consumed with the skid full.
- After flush_i at edge N, valid_o=0 and ready_o=1 from edge N onward.
- A bypass lands on the same edge as the write-back: wb in cycle N is visible on data*_o from cycle N+1.

## Structure
- Shared package pipe_pkg holds:
  - ALU control constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_MUL=4.
  - The ex_entry_t struct: rs, rt, data1, data2, alu_ctrl, rd, reg_write.
- One sub-module, ex_bypass_update: a combinational block taking (entry, wb_en, wb_rd, wb_data) and returning the updated entry. It is instanced three times: incoming, head and skid.

## Test plan
- Reset, then one op (add, data1=5, data2=7, rd=3) with ready_i=1 → valid_o=1 with those values one cycle later, count_o=1, then 0.
- ready_i=0 and three consecutive valid_i → first two accepted, ready_o=0 after the second, count_o=2. Release ready_i → ops emerge in order, and the third is accepted once ready_o=1.
- Head holds rs=4, data1=1 with ready_i=0; pulse wb_en_i, wb_rd_i=4, wb_data_i=99 → data1_o=99 next cycle. Repeat with wb_rd_i=0 → no change.
- Incoming op with rs=rt=6 in the same cycle as write-back to r6 with value 0x55 → captured data1=data2=0x55.
- Full buffer, flush_i=1 together with valid_i=1 → next cycle valid_o=0, count_o=0, ready_o=1; the input is dropped.
- alu_ctrl=6 at the head → illegal_o=1. Assert rst_i=0 mid-stream → valid_o and count_o are 0 immediately, with no clock edge.
